// File: rtl/spi_slave_rx.sv
`default_nettype none
// ============================================================================
// spi_slave_rx : 4-wire LCD SPI receiver, {dc,byte} words into a show-ahead FIFO
// Rev 1.0
// ============================================================================
module spi_slave_rx #(
  parameter int SYNC_STAGES = 2,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       spi_sck,
  input  logic       spi_mosi,
  input  logic       spi_dc,
  input  logic       spi_cs,
  input  logic       rd_en,
  output logic [8:0] rx_data,
  output logic       rx_empty,
  output logic       rx_full,
  output logic       overflow,
  output logic       frame_err,
  output logic       busy
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] PTR_ONE  = 1;
  localparam logic [3:0]  IDLE_LVL = 4'b0101;  // {sck, cs, mosi, dc}

  localparam logic [0:0] ST_IDLE  = 1'b0;
  localparam logic [0:0] ST_SHIFT = 1'b1;

  logic [3:0] sync_q [SYNC_STAGES];
  logic       sck_s, cs_s, mosi_s, dc_s, sck_prev_q, sck_rise;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) sync_q[i] <= IDLE_LVL;
      sck_prev_q <= 1'b0;
    end else begin
      sync_q[0] <= {spi_sck, spi_cs, spi_mosi, spi_dc};
      for (int i = 1; i < SYNC_STAGES; i++) sync_q[i] <= sync_q[i-1];
      sck_prev_q <= sck_s;
    end
  end

  assign {sck_s, cs_s, mosi_s, dc_s} = sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_s & ~sck_prev_q;
  assign busy     = ~cs_s;

  logic [0:0] state_q, state_d;
  logic [2:0] bit_cnt_q, bit_cnt_d;
  logic [7:0] shift_q, shift_d;
  logic [8:0] wr_word_q, wr_word_d;
  logic       wr_valid_q, wr_valid_d;
  logic       frame_err_q, frame_err_d;

  always_comb begin
    state_d     = state_q;
    bit_cnt_d   = bit_cnt_q;
    shift_d     = shift_q;
    wr_word_d   = wr_word_q;
    wr_valid_d  = 1'b0;
    frame_err_d = 1'b0;
    case (state_q)
      ST_IDLE: begin
        bit_cnt_d = 3'd0;
        shift_d   = 8'd0;
        if (!cs_s) state_d = ST_SHIFT;
      end
      ST_SHIFT: begin
        if (cs_s) begin
          state_d     = ST_IDLE;
          bit_cnt_d   = 3'd0;
          shift_d     = 8'd0;
          frame_err_d = (bit_cnt_q != 3'd0);
        end else if (sck_rise) begin
          shift_d   = {shift_q[6:0], mosi_s};
          bit_cnt_d = bit_cnt_q + 3'd1;
          // DC is only meaningful at the final bit of each byte
          if (bit_cnt_q == 3'd7) begin
            wr_valid_d = 1'b1;
            wr_word_d  = {dc_s, shift_q[6:0], mosi_s};
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      bit_cnt_q   <= 3'd0;
      shift_q     <= 8'd0;
      wr_word_q   <= 9'd0;
      wr_valid_q  <= 1'b0;
      frame_err_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      bit_cnt_q   <= bit_cnt_d;
      shift_q     <= shift_d;
      wr_word_q   <= wr_word_d;
      wr_valid_q  <= wr_valid_d;
      frame_err_q <= frame_err_d;
    end
  end

  assign frame_err = frame_err_q;

  logic [8:0]  mem_q [FIFO_DEPTH];
  logic [AW:0] wr_ptr_q, rd_ptr_q;
  logic        overflow_q, do_pop, do_push, do_drop;

  assign rx_empty = (wr_ptr_q == rd_ptr_q);
  assign rx_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                    (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
  assign do_pop   = rd_en & ~rx_empty;
  // A pop in the same cycle frees the slot, so a write at full still lands
  assign do_push  = wr_valid_q & (~rx_full | do_pop);
  assign do_drop  = wr_valid_q & rx_full & ~do_pop;

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < FIFO_DEPTH; i++) mem_q[i] <= 9'd0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      overflow_q <= 1'b0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q[AW-1:0]] <= wr_word_q;
        wr_ptr_q <= wr_ptr_q + PTR_ONE;
      end
      if (do_pop)  rd_ptr_q   <= rd_ptr_q + PTR_ONE;
      if (do_drop) overflow_q <= 1'b1;
    end
  end

  assign rx_data  = mem_q[rd_ptr_q[AW-1:0]];
  assign overflow = overflow_q;

endmodule
`default_nettype wire

// File: tb/tb_spi_slave_rx.sv
`default_nettype none
// Bench for spi_slave_rx: directed vector table plus randomized traffic vs. a queue model.
module tb_spi_slave_rx;
  localparam int S = 2;
  localparam int D = 4;

  logic       clk = 1'b0;
  logic       rst, sck, mosi, dc, cs, rd_en;
  logic [8:0] rx_data;
  logic       rx_empty, rx_full, overflow, frame_err, busy;

  always #5 clk = ~clk;

  spi_slave_rx #(.SYNC_STAGES(S), .FIFO_DEPTH(D)) dut (
    .clk(clk), .rst(rst), .spi_sck(sck), .spi_mosi(mosi), .spi_dc(dc),
    .spi_cs(cs), .rd_en(rd_en), .rx_data(rx_data), .rx_empty(rx_empty),
    .rx_full(rx_full), .overflow(overflow), .frame_err(frame_err), .busy(busy)
  );

  typedef struct {
    logic       dc;
    logic [7:0] data;
    logic [8:0] exp;
  } vec_t;
  vec_t tv [5];

  int         checks = 0;
  int         failures = 0;
  int         fe_cnt = 0;
  int         fe_long = 0;
  logic       fe_prev = 1'b0;
  logic [8:0] mq [$];
  logic       m_ovf = 1'b0;

  always @(negedge clk) begin
    if (frame_err) fe_cnt++;
    if (frame_err && fe_prev) fe_long++;
    fe_prev = frame_err;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic model_push(input logic [8:0] w);
    if (mq.size() < D) mq.push_back(w);
    else m_ovf = 1'b1;
  endtask

  task automatic cs_lo();
    cs = 1'b0;
    repeat (2) @(negedge clk);
  endtask

  task automatic cs_hi();
    sck = 1'b0;
    cs  = 1'b1;
    repeat (S + 3) @(negedge clk);
  endtask

  // mode 0: plain, 1: check write latency, 2: pop coinciding with the FIFO write
  task automatic send_word(input logic [7:0] b, input logic dcv, input int nbits,
                           input int h, input int mode);
    for (int i = 0; i < nbits; i++) begin
      sck  = 1'b0;
      mosi = b[7-i];
      dc   = (i == 7) ? dcv : 1'($urandom);
      repeat (h) @(negedge clk);
      sck = 1'b1;
      if (i == 7 && mode == 1) begin
        for (int k = 0; k <= S; k++) begin
          @(negedge clk);
          if (k == S) chk("latency_before", rx_empty, 1);
        end
        @(negedge clk);
        chk("latency_at", rx_empty, 0);
      end else if (i == 7 && mode == 2) begin
        repeat (S + 1) @(negedge clk);
        if (mq.size() > 0) chk("simul_head", rx_data, mq[0]);
        else chk("simul_model_nonempty", 0, 1);
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
      end else begin
        repeat (h) @(negedge clk);
      end
    end
    sck = 1'b0;
    if (nbits == 8) begin
      repeat (S + 3) @(negedge clk);
      model_push({dcv, b});
    end
  endtask

  task automatic pop_chk(input string nm);
    if (mq.size() == 0) begin
      chk({nm, "_empty"}, rx_empty, 1);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      @(negedge clk);
      chk({nm, "_still_empty"}, rx_empty, 1);
    end else begin
      chk({nm, "_nonempty"}, rx_empty, 0);
      chk({nm, "_data"}, rx_data, mq[0]);
      rd_en = 1'b1;
      @(negedge clk);
      rd_en = 1'b0;
      void'(mq.pop_front());
    end
  endtask

  task automatic pop_exp(input string nm, input logic [8:0] exp);
    chk({nm, "_nonempty"}, rx_empty, 0);
    chk({nm, "_data"}, rx_data, exp);
    rd_en = 1'b1;
    @(negedge clk);
    rd_en = 1'b0;
    if (mq.size() > 0) void'(mq.pop_front());
  endtask

  initial begin
    int f0, r;
    tv[0] = '{1'b0, 8'h2A, 9'h02A};
    tv[1] = '{1'b0, 8'h11, 9'h011};
    tv[2] = '{1'b1, 8'hA5, 9'h1A5};
    tv[3] = '{1'b1, 8'hFF, 9'h1FF};
    tv[4] = '{1'b1, 8'h3C, 9'h13C};

    rst = 1'b1; sck = 1'b0; mosi = 1'b0; dc = 1'b1; cs = 1'b1; rd_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_rx_data", rx_data, 9'h000);
    chk("rst_empty", rx_empty, 1);
    chk("rst_full", rx_full, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_frame_err", frame_err, 0);
    chk("rst_busy", busy, 0);
    rst = 1'b0;
    @(negedge clk);

    // single command with latency check
    cs_lo();
    chk("busy_on", busy, 1);
    f0 = fe_cnt;
    send_word(tv[0].data, tv[0].dc, 8, 1, 1);
    cs_hi();
    chk("busy_off", busy, 0);
    chk("single_no_fe", fe_cnt, f0);
    pop_exp("single", tv[0].exp);

    // burst under one CS
    cs_lo();
    for (int i = 1; i <= 3; i++) send_word(tv[i].data, tv[i].dc, 8, 1, 0);
    chk("burst_not_full", rx_full, 0);
    cs_hi();
    for (int i = 1; i <= 3; i++) pop_exp("burst", tv[i].exp);
    chk("burst_drained", rx_empty, 1);

    // framing error then a good byte
    cs_lo();
    f0 = fe_cnt;
    send_word(8'hC5, 1'b0, 5, 1, 0);
    cs_hi();
    chk("frame_err_count", fe_cnt, f0 + 1);
    chk("frame_err_width", fe_long, 0);
    chk("frame_fifo_empty", rx_empty, 1);
    cs_lo();
    send_word(tv[4].data, tv[4].dc, 8, 2, 0);
    cs_hi();
    pop_exp("after_frame", tv[4].exp);

    // simultaneous push and pop at full
    cs_lo();
    for (int i = 0; i < D; i++) send_word(8'($urandom), 1'($urandom), 8, 1, 0);
    chk("simul_full_before", rx_full, 1);
    send_word(8'h96, 1'b1, 8, 1, 2);
    chk("simul_full_after", rx_full, 1);
    chk("simul_no_overflow", overflow, 0);
    cs_hi();
    for (int i = 0; i < D; i++) pop_chk("simul_drain");
    chk("simul_empty", rx_empty, 1);

    // overflow
    cs_lo();
    for (int i = 0; i < D + 1; i++) send_word(8'($urandom), 1'($urandom), 8, 1, 0);
    cs_hi();
    chk("ovf_full", rx_full, 1);
    chk("ovf_flag", overflow, 1);
    for (int i = 0; i < D; i++) pop_chk("ovf_drain");
    chk("ovf_empty", rx_empty, 1);
    repeat (20) @(negedge clk);
    chk("ovf_sticky", overflow, 1);

    // reset mid-word
    cs_lo();
    send_word(8'h5A, 1'b0, 8, 1, 0);
    send_word(8'hF0, 1'b1, 4, 1, 0);
    f0 = fe_cnt;
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_empty", rx_empty, 1);
    chk("mid_rst_full", rx_full, 0);
    chk("mid_rst_overflow", overflow, 0);
    chk("mid_rst_busy", busy, 0);
    chk("mid_rst_data", rx_data, 9'h000);
    sck = 1'b0; cs = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    mq.delete();
    m_ovf = 1'b0;
    repeat (S + 4) @(negedge clk);
    chk("mid_rst_no_fe", fe_cnt, f0);
    chk("mid_rst_still_empty", rx_empty, 1);

    // pop while empty, then a normal word
    pop_chk("empty_pop");
    cs_lo();
    send_word(8'h77, 1'b1, 8, 1, 0);
    cs_hi();
    pop_chk("after_empty_pop");

    // randomized traffic against the queue model
    for (int n = 0; n < 80; n++) begin
      r = int'($urandom_range(0, 9));
      if (r < 5) begin
        if (cs) cs_lo();
        send_word(8'($urandom), 1'($urandom), 8, int'($urandom_range(1, 3)), 0);
      end else if (r < 6) begin
        if (cs) cs_lo();
        f0 = fe_cnt;
        send_word(8'($urandom), 1'b0, int'($urandom_range(1, 7)),
                  int'($urandom_range(1, 3)), 0);
        cs_hi();
        chk("rnd_frame_err", fe_cnt, f0 + 1);
      end else if (r < 7) begin
        f0 = fe_cnt;
        if (!cs) cs_hi();
        chk("rnd_clean_cs", fe_cnt, f0);
      end else begin
        pop_chk("rnd_pop");
      end
    end
    if (!cs) cs_hi();
    chk("rnd_overflow", overflow, m_ovf);
    for (int i = 0; i < D && mq.size() > 0; i++) pop_chk("rnd_drain");
    chk("rnd_final_empty", rx_empty, 1);
    chk("frame_err_never_wide", fe_long, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
`default_nettype wire
